// File: rtl/axi_lite_master.sv
// axi_lite_master
// ---------------------------------------------------------------------------
// Single-outstanding AXI4-Lite initiator. A command taken on the cmd_* port
// (one read or one write) is turned into AXI4-Lite channel handshakes, and
// the outcome (read data plus BRESP/RRESP) is returned on the rsp_* port.
// A saturating counter tracks how many responses came back non-OKAY.
//
// Ports
//   m_axi_aclk, m_axi_areset   clock, synchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (cmd_ready = block idle)
//   cmd_write                  1 = write, 0 = read
//   cmd_addr                   byte address, forwarded unchanged
//   cmd_wdata / cmd_wstrb      write payload (ignored for reads)
//   rsp_valid / rsp_ready      response handshake
//   rsp_write                  echo of the command direction
//   rsp_rdata                  read data (0 for writes)
//   rsp_resp                   captured BRESP / RRESP
//   err_count                  saturating count of non-OKAY responses
//   m_axi_aw* / w* / b*        AXI4-Lite write address, data, response
//   m_axi_ar* / r*             AXI4-Lite read address, data
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module axi_lite_master #(
  parameter int         M_AXI_DATA_WIDTH = 32,
  parameter int         M_AXI_ADDR_WIDTH = 4,
  parameter logic [2:0] AXI_PROT         = 3'b000
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,

  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [7:0]                    err_count,

  output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,

  output logic [M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,

  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,

  input  logic [M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int STRB_WIDTH = M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_RSP
  } state_t;

  state_t                      r_state,       w_state_next;
  logic                        r_cmd_ready,   w_cmd_ready_next;
  logic                        r_awvalid,     w_awvalid_next;
  logic                        r_wvalid,      w_wvalid_next;
  logic                        r_bready,      w_bready_next;
  logic                        r_arvalid,     w_arvalid_next;
  logic                        r_rready,      w_rready_next;
  logic                        r_aw_done,     w_aw_done_next;
  logic                        r_w_done,      w_w_done_next;
  logic [M_AXI_ADDR_WIDTH-1:0] r_awaddr,      w_awaddr_next;
  logic [M_AXI_ADDR_WIDTH-1:0] r_araddr,      w_araddr_next;
  logic [M_AXI_DATA_WIDTH-1:0] r_wdata,       w_wdata_next;
  logic [STRB_WIDTH-1:0]       r_wstrb,       w_wstrb_next;
  logic                        r_rsp_valid,   w_rsp_valid_next;
  logic                        r_rsp_write,   w_rsp_write_next;
  logic [M_AXI_DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata_next;
  logic [1:0]                  r_rsp_resp,    w_rsp_resp_next;
  logic [7:0]                  r_err_count,   w_err_count_next;

  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_b_hs;
  logic                        w_ar_hs;
  logic                        w_r_hs;
  logic                        w_capture;
  logic [1:0]                  w_capture_resp;

  // A channel transfer only counts while our own valid/ready is up, so a
  // slave asserting bvalid/rvalid early is ignored until we are ready.
  assign w_aw_hs = r_awvalid && m_axi_awready;
  assign w_w_hs  = r_wvalid  && m_axi_wready;
  assign w_b_hs  = r_bready  && m_axi_bvalid;
  assign w_ar_hs = r_arvalid && m_axi_arready;
  assign w_r_hs  = r_rready  && m_axi_rvalid;

  // State register and every registered output. Reset also discards any
  // in-flight command, so no response is produced for it.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_err_count <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_cmd_ready <= w_cmd_ready_next;
      r_awvalid   <= w_awvalid_next;
      r_wvalid    <= w_wvalid_next;
      r_bready    <= w_bready_next;
      r_arvalid   <= w_arvalid_next;
      r_rready    <= w_rready_next;
      r_aw_done   <= w_aw_done_next;
      r_w_done    <= w_w_done_next;
      r_awaddr    <= w_awaddr_next;
      r_araddr    <= w_araddr_next;
      r_wdata     <= w_wdata_next;
      r_wstrb     <= w_wstrb_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_write <= w_rsp_write_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_resp  <= w_rsp_resp_next;
      r_err_count <= w_err_count_next;
    end
  end

  // Next-state and next-output logic. Every register holds by default and
  // each state only changes what its handshake affects.
  always_comb begin
    w_state_next     = r_state;
    w_cmd_ready_next = r_cmd_ready;
    w_awvalid_next   = r_awvalid;
    w_wvalid_next    = r_wvalid;
    w_bready_next    = r_bready;
    w_arvalid_next   = r_arvalid;
    w_rready_next    = r_rready;
    w_aw_done_next   = r_aw_done;
    w_w_done_next    = r_w_done;
    w_awaddr_next    = r_awaddr;
    w_araddr_next    = r_araddr;
    w_wdata_next     = r_wdata;
    w_wstrb_next     = r_wstrb;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_write_next = r_rsp_write;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_resp_next  = r_rsp_resp;
    w_err_count_next = r_err_count;
    w_capture        = 1'b0;
    w_capture_resp   = 2'b00;

    case (r_state)
      S_IDLE: begin
        // cmd_ready rises in the first cycle after reset release.
        w_cmd_ready_next = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready_next = 1'b0;
          if (cmd_write) begin
            w_awaddr_next  = cmd_addr;
            w_wdata_next   = cmd_wdata;
            w_wstrb_next   = cmd_wstrb;
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
            w_aw_done_next = 1'b0;
            w_w_done_next  = 1'b0;
            w_state_next   = S_WR_REQ;
          end else begin
            w_araddr_next  = cmd_addr;
            w_arvalid_next = 1'b1;
            w_state_next   = S_RD_REQ;
          end
        end
      end

      S_WR_REQ: begin
        // AW and W finish independently; move on once both have landed,
        // whether that is in one cycle or spread across several.
        if (w_aw_hs) begin
          w_awvalid_next = 1'b0;
          w_aw_done_next = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_next = 1'b0;
          w_w_done_next = 1'b1;
        end
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_bready_next = 1'b1;
          w_state_next  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (w_b_hs) begin
          w_bready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_write_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_resp_next  = m_axi_bresp;
          w_capture        = 1'b1;
          w_capture_resp   = m_axi_bresp;
          w_state_next     = S_RSP;
        end
      end

      S_RD_REQ: begin
        if (w_ar_hs) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = S_RD_RESP;
        end
      end

      S_RD_RESP: begin
        if (w_r_hs) begin
          w_rready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_write_next = 1'b0;
          w_rsp_rdata_next = m_axi_rdata;
          w_rsp_resp_next  = m_axi_rresp;
          w_capture        = 1'b1;
          w_capture_resp   = m_axi_rresp;
          w_state_next     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_next = 1'b0;
          w_cmd_ready_next = 1'b1;
          w_state_next     = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Error counter sticks at 255 rather than wrapping.
    if (w_capture && (w_capture_resp != 2'b00) && (r_err_count != 8'hFF)) begin
      w_err_count_next = r_err_count + 8'd1;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign err_count     = r_err_count;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
